// File: rtl/bandit_environment.sv
// Bandit environment: Bernoulli reward per arm from a threshold table and LFSR.
// Macro BANDIT_ENVIRONMENT_STATS_EN adds stats_clear, pull_count, hit_count.
// Ports: clock, reset (async, active low);
//   action_valid/action_ready/action_data: arm index stream in;
//   reward_valid/reward_ready/reward_data: reward stream out;
//   config_valid/config_addr/config_data: probability table write port.
module bandit_environment #(
    parameter int                      ACTION_WIDTH = 8,
    parameter int                      REWARD_WIDTH = 8,
    parameter logic [REWARD_WIDTH-1:0] REWARD_HIT   = 8'hFF,
    parameter logic [REWARD_WIDTH-1:0] REWARD_MISS  = 8'h00,
    parameter logic [15:0]             SEED         = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    action_valid,
    input  logic [ACTION_WIDTH-1:0] action_data,
    output logic                    action_ready,
    output logic                    reward_valid,
    output logic [REWARD_WIDTH-1:0] reward_data,
    input  logic                    reward_ready,
`ifdef BANDIT_ENVIRONMENT_STATS_EN
    input  logic                    stats_clear,
    output logic [31:0]             pull_count,
    output logic [31:0]             hit_count,
`endif
    input  logic                    config_valid,
    input  logic [ACTION_WIDTH-1:0] config_addr,
    input  logic [7:0]              config_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  table_q [2**ACTION_WIDTH];
    logic [7:0]  thresh_q;
    logic [15:0] lfsr_q;
    logic        hit;
    logic        action_fire;
    logic        reward_fire;

    assign action_fire = action_valid & action_ready;
    assign reward_fire = reward_valid & reward_ready;

    // Galois step, taps 16'hB400, shifting right
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (action_fire) state_d = DRAW;
            DRAW:    state_d = RESPOND;
            RESPOND: if (reward_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // action_ready is held low for as long as reset is asserted
    always_comb begin
        action_ready = (state_q == IDLE) & reset;
        reward_valid = (state_q == RESPOND);
    end

    // lfsr_q is already the post-advance value while in DRAW
    assign hit = (thresh_q == 8'hFF) | (lfsr_q[7:0] < thresh_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q      <= SEED;
            thresh_q    <= '0;
            reward_data <= REWARD_MISS;
        end else begin
            if (action_fire) begin
                thresh_q <= table_q[action_data];
                lfsr_q   <= lfsr_step(lfsr_q);
            end
            if (state_q == DRAW) begin
                reward_data <= hit ? REWARD_HIT : REWARD_MISS;
            end
        end
    end

    // Not reset: contents survive reset; a colliding read sees the old value
    always_ff @(posedge clock) begin
        if (config_valid) table_q[config_addr] <= config_data;
    end

`ifdef BANDIT_ENVIRONMENT_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pull_count <= '0;
            hit_count  <= '0;
        end else if (stats_clear) begin
            pull_count <= '0;
            hit_count  <= '0;
        end else if (reward_fire) begin
            if (pull_count != '1) pull_count <= pull_count + 32'd1;
            if (reward_data == REWARD_HIT && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bandit_environment.sv
// Scoreboard bench for bandit_environment.
// Directed actions push expected rewards; a monitor pops on reward transfer.
module tb_bandit_environment;

    logic        clock;
    logic        reset;
    logic        action_valid;
    logic [7:0]  action_data;
    logic        action_ready;
    logic        reward_valid;
    logic [7:0]  reward_data;
    logic        reward_ready;
    logic        config_valid;
    logic [7:0]  config_addr;
    logic [7:0]  config_data;
`ifdef BANDIT_ENVIRONMENT_STATS_EN
    logic        stats_clear;
    logic [31:0] pull_count;
    logic [31:0] hit_count;
`endif

    int          passed = 0;
    int          total = 0;
    int          obs_hits = 0;
    logic [7:0]  sb[$];
    logic [7:0]  tbl_m [256];
    logic [15:0] lfsr_m = 16'hACE1;

    bandit_environment dut (
        .clock        (clock),
        .reset        (reset),
        .action_valid (action_valid),
        .action_data  (action_data),
        .action_ready (action_ready),
        .reward_valid (reward_valid),
        .reward_data  (reward_data),
        .reward_ready (reward_ready),
`ifdef BANDIT_ENVIRONMENT_STATS_EN
        .stats_clear  (stats_clear),
        .pull_count   (pull_count),
        .hit_count    (hit_count),
`endif
        .config_valid (config_valid),
        .config_addr  (config_addr),
        .config_data  (config_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] step(input logic [15:0] s);
        step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: compare every reward transfer against the scoreboard
    always @(negedge clock) begin
        if (reset && reward_valid && reward_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL reward_unexpected: got %0h, expected none",
                         reward_data);
            end else begin
                check("reward", {24'd0, reward_data}, {24'd0, sb.pop_front()});
                if (reward_data == 8'hFF) obs_hits++;
            end
        end
    end

    task automatic cfg(input logic [7:0] a, input logic [7:0] d);
        @(posedge clock);
        #1;
        config_valid = 1'b1;
        config_addr  = a;
        config_data  = d;
        @(posedge clock);
        #1;
        config_valid = 1'b0;
        tbl_m[a] = d;
    endtask

    // Caller must be just after a rising edge
    task automatic send_action(input logic [7:0] arm, input bit col,
                               input logic [7:0] cd, output logic [7:0] e);
        int n;
        logic [7:0] thr;
        n = 0;
        e = 8'h00;
        action_valid = 1'b1;
        action_data  = arm;
        if (col) begin
            config_valid = 1'b1;
            config_addr  = arm;
            config_data  = cd;
        end
        @(negedge clock);
        while (!action_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!action_ready) begin
            total++;
            $display("FAIL accept: action_ready=0 after 20 cycles, expected 1");
        end else begin
            thr    = tbl_m[arm];
            lfsr_m = step(lfsr_m);
            e = (thr == 8'hFF || lfsr_m[7:0] < thr) ? 8'hFF : 8'h00;
            sb.push_back(e);
        end
        if (col) tbl_m[arm] = cd;
        @(posedge clock);
        #1;
        action_valid = 1'b0;
        config_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        int model_hits;
        reset        = 1'b1;
        action_valid = 1'b0;
        action_data  = '0;
        reward_ready = 1'b0;
        config_valid = 1'b0;
        config_addr  = '0;
        config_data  = '0;
`ifdef BANDIT_ENVIRONMENT_STATS_EN
        stats_clear  = 1'b0;
`endif
        #3 reset = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_action_ready", action_ready, 0);
        check("rst_reward_valid", reward_valid, 0);
        check("rst_reward_data", reward_data, 8'h00);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rel_action_ready", action_ready, 1);

        // Always-hit arm and latency; first step from ACE1 is E270
        reward_ready = 1'b1;
        cfg(8'd3, 8'hFF);
        send_action(8'd3, 1'b0, 8'h00, e);
        check("lfsr_first_step", dut.lfsr_q, 16'hE270);
        @(negedge clock);
        check("draw_reward_valid", reward_valid, 0);
        check("draw_action_ready", action_ready, 0);
        @(negedge clock);
        check("lat_reward_valid", reward_valid, 1);
        check("lat_reward_data", reward_data, 8'hFF);
        @(negedge clock);
        check("ready_return", action_ready, 1);
        @(posedge clock);
        #1;
        drain();

        // Never-hit arm, 100 pulls
        cfg(8'd7, 8'h00);
        for (int i = 0; i < 100; i++) send_action(8'd7, 1'b0, 8'h00, e);
        drain();
        check("lfsr_after_never", dut.lfsr_q, lfsr_m);

        // Backpressure with a second action offered
        cfg(8'd5, 8'hFF);
        reward_ready = 1'b0;
        send_action(8'd5, 1'b0, 8'h00, e);
        action_valid = 1'b1;
        action_data  = 8'd5;
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_reward_valid", reward_valid, 1);
            check("bp_reward_data", reward_data, 8'hFF);
            check("bp_action_ready", action_ready, 0);
        end
        check("bp_lfsr_held", dut.lfsr_q, lfsr_m);
        @(posedge clock);
        #1;
        action_valid = 1'b0;
        reward_ready = 1'b1;
        drain();

        // Statistics, threshold 0x80
`ifdef BANDIT_ENVIRONMENT_STATS_EN
        stats_clear = 1'b1;
        @(posedge clock);
        #1 stats_clear = 1'b0;
`endif
        cfg(8'd1, 8'h80);
        obs_hits   = 0;
        model_hits = 0;
        for (int i = 0; i < 1000; i++) begin
            send_action(8'd1, 1'b0, 8'h00, e);
            if (e == 8'hFF) model_hits++;
        end
        drain();
        check("stat_hits_model", obs_hits, model_hits);
        total++;
        if (obs_hits >= 400 && obs_hits <= 600) passed++;
        else $display("FAIL stat_hits_range: got %0d, expected 400..600",
                      obs_hits);
`ifdef BANDIT_ENVIRONMENT_STATS_EN
        check("pull_count", pull_count, 1000);
        check("hit_count", hit_count, model_hits);
        stats_clear = 1'b1;
        @(posedge clock);
        #1 stats_clear = 1'b0;
        @(negedge clock);
        check("clr_pull_count", pull_count, 0);
        check("clr_hit_count", hit_count, 0);
        @(posedge clock);
        #1;
`endif

        // Reset while holding a reward, then write/read collision
        cfg(8'd2, 8'h00);
        reward_ready = 1'b0;
        send_action(8'd5, 1'b0, 8'h00, e);
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_valid", reward_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", reward_valid, 0);
        check("mid_rst_lfsr", dut.lfsr_q, 16'hACE1);
        check("mid_rst_ready", action_ready, 0);
        sb.delete();
        lfsr_m = 16'hACE1;
        @(posedge clock);
        #1;
        reset        = 1'b1;
        reward_ready = 1'b1;
        send_action(8'd2, 1'b1, 8'hFF, e);
        check("collide_model_old", e, 8'h00);
        send_action(8'd2, 1'b0, 8'h00, e);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
